frame_serializer: RTL and testbench
===================================

// Module: frame_serializer
// PURPOSE
//   Consumer for the ping-pong buffer read side. On each full-buffer pulse it drains
//   DEPTH signed samples over the read ready/valid interface and emits them as a framed
//   byte stream for the UART/host link.
//   Frame format: SYNC_BYTE, sequence byte, DEPTH*WIDTH/8 data bytes (MSB first), XOR checksum.
// PARAMETERS
//   WIDTH      32     sample width in bits; must be a multiple of 8 (8/16/32)
//   DEPTH      16     samples per frame; must match the buffer depth
//   SYNC_BYTE  8'hA5  first byte of every frame
// PORTS
//   clk_i            in   1      system clock
//   rst_ni           in   1      reset, asynchronous, active-low
//   buffer_ready_i   in   1      1-cycle pulse: full buffer available for reading
//   read_data_i      in   WIDTH  signed sample from buffer read port
//   read_valid_i     in   1      read_data_i valid
//   read_ready_o     out  1      serializer ready to take one sample
//   byte_o           out  8      output byte
//   byte_valid_o     out  1      byte_o valid
//   byte_ready_i     in   1      downstream accepts byte
//   frame_count_o    out  8      completed frames, wraps 255->0
//   frame_overrun_o  out  1      1-cycle pulse: buffer_ready_i arrived while busy
//   busy_o           out  1      high in every state except IDLE
// BEHAVIOUR
//   Reset: all outputs 0; state IDLE; sample count, byte index, checksum and seq = 0.
//     Reset asserted mid-frame aborts immediately: byte_valid_o and read_ready_o drop asynchronously.
//   Handshakes:
//     Sample transfer on read_valid_i && read_ready_o.
//     Byte transfer on byte_valid_o && byte_ready_i.
//     While byte_valid_o && !byte_ready_i, byte_o is held stable.
//     Next byte may be valid the cycle after a transfer (1 byte/cycle max).
//   FSM:
//     IDLE  : on buffer_ready_i -> SYNC; latch seq = frame_count_o; clear checksum and sample count.
//     SYNC  : byte_o = SYNC_BYTE; on transfer -> SEQ.
//     SEQ   : byte_o = seq; on transfer -> LOAD.
//     LOAD  : read_ready_o = 1 (decoded from state register).
//             On sample transfer, capture read_data_i into shift register, sample count +1, -> SHIFT.
//             Exactly one sample is accepted per LOAD visit.
//     SHIFT : present WIDTH/8 bytes, MSB first; checksum ^= each byte on transfer.
//             After the last byte: sample count < DEPTH -> LOAD, else -> CSUM.
//     CSUM  : byte_o = checksum; on transfer -> IDLE, frame_count_o +1 (mod 256).
//   Latency: buffer_ready_i in cycle N -> byte_valid_o=1 with SYNC_BYTE in N+1.
//   Checksum: 8-bit XOR of data bytes only; SYNC and SEQ bytes are excluded.
//   Frame length: 3 + DEPTH*WIDTH/8 bytes (67 at defaults).
//   Overrun: buffer_ready_i while state != IDLE -> frame_overrun_o=1 next cycle.
//     Pulse is ignored; current frame finishes unchanged; no new frame starts from it.
//   Simultaneous: buffer_ready_i in the cycle CSUM transfers -> counts as overrun (state not IDLE).
//   Sign is irrelevant to serialization; bytes are raw two's-complement bits.
//   read_data_i is sampled only at the handshake; its value outside the handshake is ignored.
// TESTING
//   1 Reset: rst_ni low at arbitrary time -> all outputs 0 in the same cycle; busy_o=0.
//   2 WIDTH=16, DEPTH=2, samples 0x1234, 0xABCD, byte_ready_i=1
//       -> bytes A5,00,12,34,AB,CD,40; frame_count_o=1.
//   3 Same frame with random byte_ready_i -> identical byte sequence;
//       byte_o stable whenever valid && !ready.
//   4 read_valid_i delayed 5 cycles in LOAD -> read_ready_o held high, byte_valid_o low,
//       no sample captured until the handshake.
//   5 Second buffer_ready_i during data bytes -> frame_overrun_o single-cycle pulse;
//       frame ends normally; returns to IDLE; no extra frame emitted.
//   6 256 frames -> seq bytes run 0x00..0xFF, then 0x00.
//       Async reset mid-SHIFT, then new frame -> seq 0x00, correct checksum.

Source files
------------

// File: rtl/frame_serializer.sv
// Drains DEPTH samples per full-buffer pulse into a framed byte stream: SYNC, seq, data bytes MSB first, XOR checksum.
// Latency: buffer_ready_i -> SYNC byte valid next cycle; byte_o is held while byte_valid_o && !byte_ready_i.
module frame_serializer #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 16,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             buffer_ready_i,
  input  logic [WIDTH-1:0] read_data_i,
  input  logic             read_valid_i,
  output logic             read_ready_o,
  output logic [7:0]       byte_o,
  output logic             byte_valid_o,
  input  logic             byte_ready_i,
  output logic [7:0]       frame_count_o,
  output logic             frame_overrun_o,
  output logic             busy_o
);

  localparam int unsigned NB = WIDTH / 8;
  localparam int unsigned BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_SEQ,
    S_LOAD,
    S_SHIFT,
    S_CSUM
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    idx_q, idx_d;
  logic [7:0]       csum_q, csum_d;
  logic [7:0]       seq_q, seq_d;
  logic [7:0]       fcnt_q, fcnt_d;
  logic             ovr_q, ovr_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      csum_q  <= '0;
      seq_q   <= '0;
      fcnt_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      seq_q   <= seq_d;
      fcnt_q  <= fcnt_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    csum_d       = csum_q;
    seq_d        = seq_q;
    fcnt_d       = fcnt_q;
    // A pulse arriving outside IDLE is only reported, never queued.
    ovr_d        = buffer_ready_i && (state_q != S_IDLE);
    read_ready_o = 1'b0;
    byte_valid_o = 1'b0;
    byte_o       = 8'h00;

    case (state_q)
      S_IDLE: begin
        if (buffer_ready_i) begin
          state_d = S_SYNC;
          seq_d   = fcnt_q;
          csum_d  = '0;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      S_SYNC: begin
        byte_valid_o = 1'b1;
        byte_o       = SYNC_BYTE;
        if (byte_ready_i) state_d = S_SEQ;
      end
      S_SEQ: begin
        byte_valid_o = 1'b1;
        byte_o       = seq_q;
        if (byte_ready_i) state_d = S_LOAD;
      end
      S_LOAD: begin
        read_ready_o = 1'b1;
        if (read_valid_i) begin
          shift_d = read_data_i;
          cnt_d   = cnt_q + CW'(1);
          idx_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        byte_valid_o = 1'b1;
        byte_o       = shift_q[WIDTH-1 -: 8];
        if (byte_ready_i) begin
          csum_d  = csum_q ^ shift_q[WIDTH-1 -: 8];
          shift_d = shift_q << 8;
          idx_d   = idx_q + BW'(1);
          if (idx_q == BW'(NB - 1)) begin
            state_d = (cnt_q < CW'(DEPTH)) ? S_LOAD : S_CSUM;
          end
        end
      end
      S_CSUM: begin
        byte_valid_o = 1'b1;
        byte_o       = csum_q;
        if (byte_ready_i) begin
          state_d = S_IDLE;
          fcnt_d  = fcnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign frame_count_o   = fcnt_q;
  assign frame_overrun_o = ovr_q;
  assign busy_o          = (state_q != S_IDLE);

endmodule

// File: tb/tb_frame_serializer.sv
// Bench for frame_serializer at WIDTH=16, DEPTH=2: directed frame table plus randomized frames against a byte-list model.
module tb_frame_serializer;

  localparam int W      = 16;
  localparam int D      = 2;
  localparam int NBYTES = 3 + D * W / 8;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         buffer_ready_i;
  logic [W-1:0] read_data_i;
  logic         read_valid_i;
  logic         read_ready_o;
  logic [7:0]   byte_o;
  logic         byte_valid_o;
  logic         byte_ready_i;
  logic [7:0]   frame_count_o;
  logic         frame_overrun_o;
  logic         busy_o;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp_fc;

  typedef struct {
    logic [W-1:0]          s0;
    logic [W-1:0]          s1;
    bit                    rnd;
    int                    dly;
    int                    ovr;
    logic [8*NBYTES-1:0]   frame;
  } vec_t;

  vec_t tbl[5];

  frame_serializer #(
    .WIDTH    (W),
    .DEPTH    (D),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .buffer_ready_i (buffer_ready_i),
    .read_data_i    (read_data_i),
    .read_valid_i   (read_valid_i),
    .read_ready_o   (read_ready_o),
    .byte_o         (byte_o),
    .byte_valid_o   (byte_valid_o),
    .byte_ready_i   (byte_ready_i),
    .frame_count_o  (frame_count_o),
    .frame_overrun_o(frame_overrun_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference frame: sync, seq, each sample split MSB-first into bytes, XOR of data bytes.
  task automatic model_frame(input logic [W-1:0] s0, input logic [W-1:0] s1, input logic [7:0] seq);
    logic [W-1:0] smp[2];
    logic [7:0]   b;
    logic [7:0]   cs;
    smp[0] = s0;
    smp[1] = s1;
    cs = 8'h00;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(seq);
    for (int i = 0; i < D; i++) begin
      for (int k = W / 8 - 1; k >= 0; k--) begin
        b = 8'((smp[i] >> (8 * k)) & 'hFF);
        exp_q.push_back(b);
        cs = cs ^ b;
      end
    end
    exp_q.push_back(cs);
  endtask

  task automatic do_reset();
    buffer_ready_i = 1'b0;
    read_valid_i   = 1'b0;
    byte_ready_i   = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_byte_valid", byte_valid_o, 0);
    chk("rst_read_ready", read_ready_o, 0);
    chk("rst_byte", byte_o, 0);
    chk("rst_frame_count", frame_count_o, 0);
    chk("rst_overrun", frame_overrun_o, 0);
    chk("rst_busy", busy_o, 0);
    @(negedge clk_i) rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  // Entered and left just after a rising edge.
  task automatic run_frame(input logic [W-1:0] s0, input logic [W-1:0] s1,
                           input bit rnd_rdy, input int delay, input int ovr_cyc);
    logic [W-1:0] smp[2];
    int           si = 0;
    int           wait_cnt = 0;
    bit           prev_stall = 1'b0;
    logic [7:0]   prev_byte = 8'h00;
    smp[0] = s0;
    smp[1] = s1;
    got_q.delete();
    buffer_ready_i = 1'b1;
    byte_ready_i   = 1'b0;
    read_valid_i   = 1'b0;
    @(posedge clk_i);
    #1 buffer_ready_i = 1'b0;
    for (int cyc = 0; cyc < 200 && got_q.size() < NBYTES; cyc++) begin
      buffer_ready_i = (cyc == ovr_cyc);
      byte_ready_i   = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      read_data_i    = W'($urandom);
      read_valid_i   = 1'b0;
      if (read_ready_o) begin
        if (wait_cnt >= delay && si < D) begin
          read_valid_i = 1'b1;
          read_data_i  = smp[si];
        end
        wait_cnt++;
      end else begin
        wait_cnt = 0;
      end
      @(negedge clk_i);
      if (cyc == 0) begin
        chk("latency_valid", byte_valid_o, 1);
        chk("latency_sync", byte_o, 8'hA5);
        chk("busy_in_frame", busy_o, 1);
      end
      chk("overrun_pulse", frame_overrun_o, (ovr_cyc >= 0 && cyc == ovr_cyc + 1));
      if (read_ready_o && !read_valid_i) chk("load_wait_no_byte", byte_valid_o, 0);
      if (prev_stall) begin
        chk("hold_valid", byte_valid_o, 1);
        chk("hold_byte", byte_o, prev_byte);
      end
      if (read_ready_o && read_valid_i) si++;
      if (byte_valid_o && byte_ready_i) got_q.push_back(byte_o);
      prev_stall = byte_valid_o && !byte_ready_i;
      prev_byte  = byte_o;
      @(posedge clk_i);
      #1;
    end
    buffer_ready_i = 1'b0;
    byte_ready_i   = 1'b0;
    read_valid_i   = 1'b0;
    chk("frame_len", got_q.size(), NBYTES);
    exp_fc = exp_fc + 8'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("idle_busy", busy_o, 0);
      chk("idle_no_byte", byte_valid_o, 0);
      chk("frame_count", frame_count_o, exp_fc);
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic cmp_frame(input string tag);
    logic [7:0] a;
    for (int k = 0; k < NBYTES; k++) begin
      a = 8'hxx;
      if (k < got_q.size()) a = got_q[k];
      chk($sformatf("%s byte%0d", tag, k), a, exp_q[k]);
    end
  endtask

  initial begin
    logic [8*NBYTES-1:0] f;
    logic [W-1:0]        r0, r1;

    rst_ni         = 1'b1;
    buffer_ready_i = 1'b0;
    read_valid_i   = 1'b0;
    read_data_i    = '0;
    byte_ready_i   = 1'b0;

    tbl[0] = '{16'h1234, 16'hABCD, 1'b0, 0, -1, 56'hA5_00_1234_ABCD_40};
    tbl[1] = '{16'h1234, 16'hABCD, 1'b1, 0, -1, 56'hA5_01_1234_ABCD_40};
    tbl[2] = '{16'h0000, 16'h0000, 1'b0, 5, -1, 56'hA5_02_0000_0000_00};
    tbl[3] = '{16'hFFFF, 16'h8001, 1'b0, 0,  4, 56'hA5_03_FFFF_8001_81};
    tbl[4] = '{16'h00FF, 16'hFF00, 1'b1, 2, -1, 56'hA5_04_00FF_FF00_00};

    do_reset();
    exp_fc = 8'd0;
    for (int i = 0; i < 5; i++) begin
      run_frame(tbl[i].s0, tbl[i].s1, tbl[i].rnd, tbl[i].dly, tbl[i].ovr);
      f = tbl[i].frame;
      exp_q.delete();
      for (int k = 0; k < NBYTES; k++) exp_q.push_back(f[8*(NBYTES-1-k) +: 8]);
      cmp_frame($sformatf("tbl%0d", i));
    end

    // Sequence byte must walk through all 256 values and wrap.
    do_reset();
    exp_fc = 8'd0;
    for (int n = 0; n < 257; n++) begin
      r0 = W'($urandom);
      r1 = W'($urandom);
      model_frame(r0, r1, exp_fc);
      run_frame(r0, r1, 1'($urandom_range(0, 1)), $urandom_range(0, 3), -1);
      cmp_frame($sformatf("rnd%0d", n));
    end

    // Abort in the middle of a sample, then confirm a clean restart.
    buffer_ready_i = 1'b1;
    byte_ready_i   = 1'b1;
    read_valid_i   = 1'b1;
    read_data_i    = 16'h5A3C;
    @(posedge clk_i);
    #1 buffer_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    @(negedge clk_i);
    chk("pre_abort_valid", byte_valid_o, 1);
    chk("pre_abort_byte", byte_o, 8'h5A);
    do_reset();
    exp_fc = 8'd0;
    r0 = W'($urandom);
    r1 = W'($urandom);
    model_frame(r0, r1, 8'h00);
    run_frame(r0, r1, 1'b1, 1, -1);
    cmp_frame("post_abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
